// File: rtl/i2c_master_if.sv
// ---------------------------------------------------------------------------
// i2c_master_if
// Request/response bundle between a local requester and the I2C master.
//   start   : request pulse (requester -> master)
//   rw      : 0 = write, 1 = read (requester -> master)
//   addr    : 7-bit target address (requester -> master)
//   wdata   : byte to write (requester -> master)
//   busy    : transaction in progress (master -> requester)
//   done    : one-clk completion pulse (master -> requester)
//   ack_err : address or write-data phase was NACKed (master -> requester)
//   rdata   : byte read from the target (master -> requester)
// Modport "master" is the requester side that issues transactions; modport
// "slave" is the side that services them, i.e. the i2c_master block itself.
// ---------------------------------------------------------------------------
interface i2c_master_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;

    modport master (
        output start, rw, addr, wdata,
        input  busy, done, ack_err, rdata
    );

    modport slave (
        input  start, rw, addr, wdata,
        output busy, done, ack_err, rdata
    );
endinterface

// File: rtl/i2c_master.sv
// ---------------------------------------------------------------------------
// i2c_master
// Single-master I2C initiator. Each accepted request runs START, address+R/W,
// address ACK, one data byte (write or read), then STOP.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset; releases the bus immediately
//   req    : request/response bundle (i2c_master_if.slave)
//   SDA    : open-drain data line, driven 0 or Z
//   SCL    : open-drain clock line, driven 0 or Z, never read back
// Parameter:
//   CLK_DIV : system clocks per SCL quarter period (>= 2)
// ---------------------------------------------------------------------------
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    i2c_master_if.slave  req,
    inout  wire          SDA,
    inout  wire          SCL
);

    localparam int QW = $clog2(CLK_DIV);
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_ADDR  = 4'd2,
        ST_AACK  = 4'd3,
        ST_WDATA = 4'd4,
        ST_WACK  = 4'd5,
        ST_RDATA = 4'd6,
        ST_RNACK = 4'd7,
        ST_STOP  = 4'd8,
        ST_DONE  = 4'd9
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [QW-1:0] qcnt_r;
    logic [1:0]    phase_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic [7:0]    wdata_r;
    logic [7:0]    rdata_r;
    logic          rw_r;
    logic          ack_err_r;
    logic          busy_r;
    logic          done_r;
    logic          sda_oe_r;
    logic          scl_oe_r;

    logic          quarter_end_s;
    logic          sample_s;
    logic          bit_end_s;
    logic          byte_end_s;
    logic          sda_in_s;
    logic          sda_oe_s;
    logic          scl_oe_s;
    logic          busy_s;
    logic          done_s;

    // Bus is sampled directly; the target only changes SDA while SCL is low,
    // and sampling happens a full quarter after SCL was released.
    assign sda_in_s      = SDA;
    assign quarter_end_s = (qcnt_r == Q_LAST);
    assign sample_s      = quarter_end_s && (phase_r == 2'd2);
    assign bit_end_s     = quarter_end_s && (phase_r == 2'd3);
    assign byte_end_s    = bit_end_s && (bit_cnt_r == 3'd7);

    // State register plus quarter/phase/bit timing counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            qcnt_r    <= {QW{1'b0}};
            phase_r   <= 2'd0;
            bit_cnt_r <= 3'd0;
        end else begin
            state_r <= state_next_s;
            // Every state change lands on a quarter boundary, so timing restarts cleanly.
            if ((state_next_s != state_r) || (state_r == ST_IDLE)) begin
                qcnt_r    <= {QW{1'b0}};
                phase_r   <= 2'd0;
                bit_cnt_r <= 3'd0;
            end else if (quarter_end_s) begin
                qcnt_r  <= {QW{1'b0}};
                phase_r <= phase_r + 2'd1;
                if (bit_end_s) begin
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
            end else begin
                qcnt_r <= qcnt_r + QW'(1'b1);
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  if (req.start) state_next_s = ST_START; else state_next_s = ST_IDLE;
            ST_START: if (quarter_end_s && (phase_r == 2'd1)) state_next_s = ST_ADDR; else state_next_s = ST_START;
            ST_ADDR:  if (byte_end_s) state_next_s = ST_AACK; else state_next_s = ST_ADDR;
            ST_AACK: begin
                // ack_err_r was updated at the q2 sample of this same bit.
                if (!bit_end_s)     state_next_s = ST_AACK;
                else if (ack_err_r) state_next_s = ST_STOP;
                else if (rw_r)      state_next_s = ST_RDATA;
                else                state_next_s = ST_WDATA;
            end
            ST_WDATA: if (byte_end_s) state_next_s = ST_WACK; else state_next_s = ST_WDATA;
            ST_WACK:  if (bit_end_s) state_next_s = ST_STOP; else state_next_s = ST_WACK;
            ST_RDATA: if (byte_end_s) state_next_s = ST_RNACK; else state_next_s = ST_RDATA;
            ST_RNACK: if (bit_end_s) state_next_s = ST_STOP; else state_next_s = ST_RNACK;
            ST_STOP:  if (bit_end_s) state_next_s = ST_DONE; else state_next_s = ST_STOP;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: desired bus pull-downs and status, registered below.
    always_comb begin
        sda_oe_s = 1'b0;
        scl_oe_s = 1'b0;
        busy_s   = (state_next_s != ST_IDLE);
        done_s   = (state_r == ST_DONE);
        case (state_r)
            ST_START: begin
                sda_oe_s = (phase_r == 2'd1);
            end
            ST_ADDR, ST_WDATA: begin
                scl_oe_s = ~phase_r[1];
                sda_oe_s = ~shift_r[7];
            end
            ST_AACK, ST_WACK, ST_RDATA, ST_RNACK: begin
                scl_oe_s = ~phase_r[1];
            end
            ST_STOP: begin
                scl_oe_s = (phase_r == 2'd0);
                sda_oe_s = ~phase_r[1];
            end
            default: begin
                sda_oe_s = 1'b0;
                scl_oe_s = 1'b0;
            end
        endcase
    end

    // Registered bus drivers and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_oe_r <= 1'b0;
            scl_oe_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            sda_oe_r <= sda_oe_s;
            scl_oe_r <= scl_oe_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    // Request capture, shift register, ACK checks and read-byte assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r   <= 8'h00;
            wdata_r   <= 8'h00;
            rdata_r   <= 8'h00;
            rw_r      <= 1'b0;
            ack_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req.start) begin
                        shift_r   <= {req.addr, req.rw};
                        wdata_r   <= req.wdata;
                        rw_r      <= req.rw;
                        ack_err_r <= 1'b0;
                    end
                end
                ST_ADDR, ST_WDATA: begin
                    if (bit_end_s) begin
                        shift_r <= {shift_r[6:0], 1'b0};
                    end
                end
                ST_AACK: begin
                    if (sample_s && sda_in_s) begin
                        ack_err_r <= 1'b1;
                    end
                    if (bit_end_s) begin
                        shift_r <= wdata_r;
                    end
                end
                ST_WACK: begin
                    if (sample_s && sda_in_s) begin
                        ack_err_r <= 1'b1;
                    end
                end
                ST_RDATA: begin
                    // shift_r is idle during a read, so it assembles the byte;
                    // rdata only updates once the whole byte is in.
                    if (sample_s) begin
                        shift_r <= {shift_r[6:0], sda_in_s};
                    end
                    if (byte_end_s) begin
                        rdata_r <= shift_r;
                    end
                end
                default: begin
                    shift_r <= shift_r;
                end
            endcase
        end
    end

    assign SDA         = sda_oe_r ? 1'b0 : 1'bz;
    assign SCL         = scl_oe_r ? 1'b0 : 1'bz;
    assign req.busy    = busy_r;
    assign req.done    = done_r;
    assign req.ack_err = ack_err_r;
    assign req.rdata   = rdata_r;

endmodule

// File: tb/tb_i2c_master.sv
// ---------------------------------------------------------------------------
// tb_i2c_master
// Self-checking bench for i2c_master: a bus monitor decodes START/STOP and
// the bit stream at SCL rising edges, a behavioural target ACKs/NACKs and
// serves read data on SCL falling edges, and each transaction is compared
// against an expected bit stream, latency and status built from the
// protocol rules.
// ---------------------------------------------------------------------------
module tb_i2c_master;
    localparam int CLK_DIV = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_master_if req_if ();
    wire sda_w;
    wire scl_w;
    pullup (sda_w);
    pullup (scl_w);

    logic slv_sda_low = 1'b0;
    assign sda_w = slv_sda_low ? 1'b0 : 1'bz;

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_if),
        .SDA   (sda_w),
        .SCL   (scl_w)
    );

    int check_cnt = 0;
    int err_cnt   = 0;

    // target behaviour for the current transaction
    logic       slv_present = 1'b0;
    logic       slv_dack    = 1'b0;
    logic [7:0] slv_rbyte   = 8'h00;
    logic       slv_rw      = 1'b0;

    // bus monitor state
    logic        prev_sda  = 1'b1;
    logic        prev_scl  = 1'b1;
    int          rise_cnt  = 0;
    int          start_cnt = 0;
    int          stop_cnt  = 0;
    int          slv_base  = 0;
    logic [31:0] bits_v    = 32'd0;

    logic [7:0] rd_model = 8'h00;

    // Monitor and target: sample the bus once per clk, away from the active edge.
    always @(negedge clk) begin
        int idx;
        if (prev_scl && scl_w && prev_sda && !sda_w) begin
            start_cnt++;
            slv_base    = rise_cnt;
            slv_sda_low = 1'b0;
        end
        if (prev_scl && scl_w && !prev_sda && sda_w) begin
            stop_cnt++;
        end
        if (!prev_scl && scl_w) begin
            bits_v = {bits_v[30:0], sda_w};
            rise_cnt++;
            if (rise_cnt - slv_base == 8) slv_rw = sda_w;
        end
        if (prev_scl && !scl_w) begin
            idx = rise_cnt - slv_base;
            if (idx == 8)                    slv_sda_low = slv_present;
            else if (idx >= 9 && idx <= 16)  slv_sda_low = slv_present && slv_rw && !slv_rbyte[16 - idx];
            else if (idx == 17)              slv_sda_low = slv_present && !slv_rw && slv_dack;
            else                             slv_sda_low = 1'b0;
        end
        prev_sda = sda_w;
        prev_scl = scl_w;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                           input logic pres, input logic dack, input logic [7:0] rd,
                           input logic poke);
        logic [31:0] exp_bits;
        logic [31:0] mask;
        int          exp_n;
        int          quarters;
        int          exp_lat;
        logic        exp_err;
        int          r0, s0, p0, cyc, busy_low;
        logic        got;

        // Reference: what the bus and the status must show for this request.
        exp_bits = {24'd0, a, r};
        exp_bits = {exp_bits[30:0], ~pres};
        exp_n    = 9;
        quarters = 2 + 9 * 4;
        if (pres) begin
            if (r) exp_bits = {exp_bits[22:0], rd, 1'b1};
            else   exp_bits = {exp_bits[22:0], wd, ~dack};
            exp_n    += 9;
            quarters += 9 * 4;
        end
        exp_bits = {exp_bits[30:0], 1'b0};
        exp_n    += 1;
        quarters += 4;
        exp_lat  = quarters * CLK_DIV + 1;
        exp_err  = !pres || (!r && !dack);
        if (pres && r) rd_model = rd;
        mask = (32'd1 << exp_n) - 32'd1;

        slv_present = pres;
        slv_dack    = dack;
        slv_rbyte   = rd;
        r0 = rise_cnt;
        s0 = start_cnt;
        p0 = stop_cnt;

        @(negedge clk);
        req_if.addr  = a;
        req_if.rw    = r;
        req_if.wdata = wd;
        req_if.start = 1'b1;
        @(posedge clk);
        #1;
        req_if.start = 1'b0;
        req_if.addr  = 7'($urandom);
        req_if.rw    = 1'($urandom);
        req_if.wdata = 8'($urandom);
        chk("busy_after_accept", req_if.busy, 1'b1);

        cyc = 0;
        got = 1'b0;
        busy_low = 0;
        while (!got && cyc < 1000) begin
            @(posedge clk);
            cyc++;
            #1;
            req_if.start = poke && (cyc == 100);
            if (poke && cyc == 100) begin
                req_if.addr  = ~a;
                req_if.wdata = ~wd;
            end
            if (req_if.done === 1'b1) got = 1'b1;
            else if (req_if.busy !== 1'b1) busy_low++;
        end
        req_if.start = 1'b0;

        chk("done_seen",    got, 1'b1);
        chk("done_latency", cyc, exp_lat);
        chk("busy_active",  busy_low, 0);
        chk("busy_at_done", req_if.busy, 1'b0);
        chk("ack_err",      req_if.ack_err, exp_err);
        chk("rdata",        req_if.rdata, rd_model);
        chk("bit_count",    rise_cnt - r0, exp_n);
        chk("bus_bits",     bits_v & mask, exp_bits);
        chk("start_cond",   start_cnt - s0, 1);
        chk("stop_cond",    stop_cnt - p0, 1);
        chk("idle_sda",     sda_w, 1'b1);
        chk("idle_scl",     scl_w, 1'b1);
        @(posedge clk);
        #1;
        chk("done_width",   req_if.done, 1'b0);
        chk("ack_err_held", req_if.ack_err, exp_err);
    endtask

    initial begin
        logic [7:0] av;
        int         r0;
        int         cyc;

        req_if.start = 1'b0;
        req_if.rw    = 1'b0;
        req_if.addr  = 7'h00;
        req_if.wdata = 8'h00;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sda",     sda_w, 1'b1);
        chk("rst_scl",     scl_w, 1'b1);
        chk("rst_busy",    req_if.busy, 1'b0);
        chk("rst_done",    req_if.done, 1'b0);
        chk("rst_ack_err", req_if.ack_err, 1'b0);
        chk("rst_rdata",   req_if.rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // directed transactions
        run_txn(7'h55, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0);
        run_txn(7'h55, 1'b1, 8'h3C, 1'b1, 1'b1, 8'hD5, 1'b0);
        run_txn(7'h12, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("nack_held_idle", req_if.ack_err, 1'b1);
        run_txn(7'h2A, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0);
        run_txn(7'h33, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b1);

        // randomized transactions
        for (int i = 0; i < 8; i++) begin
            run_txn(7'($urandom), 1'($urandom), 8'($urandom),
                    ($urandom_range(3, 0) != 0), 1'($urandom), 8'($urandom), 1'($urandom));
        end

        // reset during bit 4 of the address byte
        slv_present = 1'b1;
        slv_dack    = 1'b1;
        av = {7'h41, 1'b0};
        r0 = rise_cnt;
        @(negedge clk);
        req_if.addr  = 7'h41;
        req_if.rw    = 1'b0;
        req_if.wdata = 8'h99;
        req_if.start = 1'b1;
        @(posedge clk);
        #1;
        req_if.start = 1'b0;
        cyc = 0;
        while (!((rise_cnt - r0 == 4) && (scl_w === 1'b0)) && cyc < 500) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("rst_wait",     (cyc < 500), 1'b1);
        chk("bit4_scl_low", scl_w, 1'b0);
        chk("bit4_sda",     sda_w, av[3]);
        #1;
        rst_n = 1'b0;
        #1;
        rd_model = 8'h00;
        chk("async_sda",   sda_w, 1'b1);
        chk("async_scl",   scl_w, 1'b1);
        chk("async_busy",  req_if.busy, 1'b0);
        chk("async_rdata", req_if.rdata, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_txn(7'($urandom), 1'b0, 8'($urandom), 1'b1, 1'b1, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end
endmodule
